// File: rtl/aclk_lcd_pkg.sv
// Shared state encodings, HD44780 command bytes and character constants for the alarm-clock LCD writer.
// Also holds the small constant helpers used to size counters and order the init commands.
package aclk_lcd_pkg;

    typedef enum logic [1:0] {
        ST_PWR_WAIT,
        ST_INIT,
        ST_IDLE,
        ST_FRAME
    } lcd_state_t;

    typedef enum logic [1:0] {
        BW_IDLE,
        BW_SETUP,
        BW_STROBE,
        BW_HOLD
    } bw_phase_t;

    localparam logic [7:0] LCD_FUNC_SET  = 8'h38;
    localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
    localparam logic [7:0] LCD_ENTRY     = 8'h06;
    localparam logic [7:0] LCD_CLEAR     = 8'h01;
    localparam logic [7:0] LCD_HOME_ADDR = 8'h80;

    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_STAR  = 8'h2A;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0:    return LCD_FUNC_SET;
            3'd1:    return LCD_DISP_ON;
            3'd2:    return LCD_ENTRY;
            default: return LCD_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/aclk_lcd_byte_writer.sv
// Purpose: drives one HD44780 bus write as SETUP / STROBE / HOLD phases of TICK cycles each.
// Latency: start in cycle C puts rs/data on the bus from C+1; done pulses in the last HOLD cycle (C+3*TICK).
// Backpressure: none; caller issues start only when idle or in the done cycle (back-to-back writes).
module aclk_lcd_byte_writer
    import aclk_lcd_pkg::*;
#(
    parameter int TICK = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic [7:0] lcd_data,
    output logic       done
);

    localparam int TW = $clog2(TICK) + 1;

    bw_phase_t       phase, phase_nxt;
    logic [TW-1:0]   tick_cnt;
    logic            tick_last;

    assign tick_last = (tick_cnt == TW'(TICK - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase    <= BW_IDLE;
            tick_cnt <= '0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
        end else begin
            phase <= phase_nxt;
            if (start || tick_last || phase == BW_IDLE)
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + 1'b1;
            // rs/data only move on start, so they stay put through the byte and between bytes
            if (start) begin
                lcd_rs   <= rs;
                lcd_data <= data;
            end
        end
    end

    always_comb begin
        phase_nxt = phase;
        if (start) begin
            phase_nxt = BW_SETUP;
        end else if (tick_last) begin
            case (phase)
                BW_SETUP:  phase_nxt = BW_STROBE;
                BW_STROBE: phase_nxt = BW_HOLD;
                default:   phase_nxt = BW_IDLE;
            endcase
        end
    end

    assign lcd_en = (phase == BW_STROBE);
    assign done   = (phase == BW_HOLD) && tick_last;

endmodule

// File: rtl/aclk_lcd_writer.sv
// Purpose: HD44780 power-up init then one "HH:MM" frame per refresh; ACLK_LCD_ALARM_ICON_EN appends an alarm icon.
// Latency: refresh sampled at edge N drops ready and starts the first SETUP at N+1; frame = bytes*3*TICK cycles.
// Backpressure: ready high only in IDLE; refreshes while busy collapse into one sticky pending frame.
module aclk_lcd_writer
    import aclk_lcd_pkg::*;
#(
    parameter int TICK       = 4,
    parameter int POWER_WAIT = 16,
    parameter int CLEAR_WAIT = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] display_time_ms_hr,
    input  logic [7:0] display_time_ls_hr,
    input  logic [7:0] display_time_ms_min,
    input  logic [7:0] display_time_ls_min,
    input  logic       sound_alarm,
    input  logic       refresh,
    output logic       ready,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data
);

`ifdef ACLK_LCD_ALARM_ICON_EN
    localparam int FRAME_BYTES = 8;
`else
    localparam int FRAME_BYTES = 6;
`endif
    localparam int         CW         = $clog2(max3(TICK, POWER_WAIT, CLEAR_WAIT)) + 1;
    localparam logic [2:0] LAST_IDX   = 3'(FRAME_BYTES - 1);
    localparam logic [2:0] CLEAR_IDX  = 3'd4;

    lcd_state_t    state, state_nxt;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic          pending;
    logic          counting;
    logic          go_frame;
    logic [7:0]    snap_ms_hr, snap_ls_hr, snap_ms_min, snap_ls_min;
    logic [7:0]    icon_byte;
    logic          bw_start, bw_rs, bw_done;
    logic [7:0]    bw_data;

`ifdef ACLK_LCD_ALARM_ICON_EN
    logic snap_alarm;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            snap_alarm <= 1'b0;
        else if (go_frame)
            snap_alarm <= sound_alarm;
    end
    assign icon_byte = snap_alarm ? ASCII_STAR : ASCII_SPACE;
`else
    logic unused_sound_alarm;
    assign unused_sound_alarm = sound_alarm;
    assign icon_byte          = ASCII_SPACE;
`endif

    assign go_frame = (state == ST_IDLE) && (refresh || pending);
    assign counting = (state == ST_PWR_WAIT) || (state == ST_INIT && idx == CLEAR_IDX);
    assign lcd_rw   = 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_PWR_WAIT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_PWR_WAIT: if (cnt == CW'(POWER_WAIT - 1)) state_nxt = ST_INIT;
            ST_INIT: begin
                // idx 0..3 walk the commands; idx 4 is the post-clear wait
                if (CLEAR_WAIT == 0) begin
                    if (bw_done && idx == 3'd3) state_nxt = ST_IDLE;
                end else if (idx == CLEAR_IDX && cnt == CW'(CLEAR_WAIT - 1)) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE:  if (go_frame) state_nxt = ST_FRAME;
            ST_FRAME: if (bw_done && idx == LAST_IDX) state_nxt = ST_IDLE;
            default:  state_nxt = ST_PWR_WAIT;
        endcase
    end

    // Next byte is issued in the done cycle of the current one so writes run back to back
    always_comb begin
        ready    = 1'b0;
        bw_start = 1'b0;
        bw_rs    = 1'b0;
        bw_data  = LCD_FUNC_SET;
        case (state)
            ST_PWR_WAIT: bw_start = (cnt == CW'(POWER_WAIT - 1));
            ST_INIT: begin
                bw_start = bw_done && (idx < 3'd3);
                bw_data  = init_cmd(idx + 3'd1);
            end
            ST_IDLE: begin
                ready    = 1'b1;
                bw_start = go_frame;
                bw_data  = LCD_HOME_ADDR;
            end
            ST_FRAME: begin
                bw_start = bw_done && (idx != LAST_IDX);
                bw_rs    = 1'b1;
                case (idx)
                    3'd0:    bw_data = snap_ms_hr;
                    3'd1:    bw_data = snap_ls_hr;
                    3'd2:    bw_data = ASCII_COLON;
                    3'd3:    bw_data = snap_ms_min;
                    3'd4:    bw_data = snap_ls_min;
                    3'd5:    bw_data = ASCII_SPACE;
                    default: bw_data = icon_byte;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            idx         <= '0;
            pending     <= 1'b0;
            snap_ms_hr  <= ASCII_SPACE;
            snap_ls_hr  <= ASCII_SPACE;
            snap_ms_min <= ASCII_SPACE;
            snap_ls_min <= ASCII_SPACE;
        end else begin
            if (state_nxt != state) begin
                cnt <= '0;
                idx <= '0;
            end else begin
                cnt <= counting ? cnt + 1'b1 : '0;
                if (bw_done) idx <= idx + 3'd1;
            end
            if (go_frame) begin
                pending     <= 1'b0;
                snap_ms_hr  <= display_time_ms_hr;
                snap_ls_hr  <= display_time_ls_hr;
                snap_ms_min <= display_time_ms_min;
                snap_ls_min <= display_time_ls_min;
            end else if (refresh && state != ST_IDLE) begin
                pending <= 1'b1;
            end
        end
    end

    aclk_lcd_byte_writer #(
        .TICK(TICK)
    ) u_byte_writer (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (bw_start),
        .rs       (bw_rs),
        .data     (bw_data),
        .lcd_en   (lcd_en),
        .lcd_rs   (lcd_rs),
        .lcd_data (lcd_data),
        .done     (bw_done)
    );

endmodule

// File: tb/tb_aclk_lcd_writer.sv
// Scoreboard bench for aclk_lcd_writer: stimulus pushes expected {rs,data} bus writes,
// a negedge monitor pops one per EN falling edge and also checks EN pulse width.
module tb_aclk_lcd_writer;

    localparam int TICK       = 4;
    localparam int POWER_WAIT = 16;
    localparam int CLEAR_WAIT = 32;
`ifdef ACLK_LCD_ALARM_ICON_EN
    localparam bit ICON_EN = 1'b1;
`else
    localparam bit ICON_EN = 1'b0;
`endif
    localparam int FRAME_BYTES = ICON_EN ? 8 : 6;
    localparam int INIT_LEN    = POWER_WAIT + 4 * 3 * TICK + CLEAR_WAIT;
    localparam int FRAME_LEN   = FRAME_BYTES * 3 * TICK;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] display_time_ms_hr, display_time_ls_hr, display_time_ms_min, display_time_ls_min;
    logic       sound_alarm;
    logic       refresh;
    logic       ready, lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_data;

    int         checks   = 0;
    int         failures = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    aclk_lcd_writer #(
        .TICK(TICK), .POWER_WAIT(POWER_WAIT), .CLEAR_WAIT(CLEAR_WAIT)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .display_time_ms_hr  (display_time_ms_hr),
        .display_time_ls_hr  (display_time_ls_hr),
        .display_time_ms_min (display_time_ms_min),
        .display_time_ls_min (display_time_ls_min),
        .sound_alarm         (sound_alarm),
        .refresh             (refresh),
        .ready               (ready),
        .lcd_rs              (lcd_rs),
        .lcd_rw              (lcd_rw),
        .lcd_en              (lcd_en),
        .lcd_data            (lcd_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void push_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h06});
        exp_q.push_back({1'b0, 8'h01});
    endfunction

    // Reference frame: address 0, then the text "HH:MM" plus optional space/icon
    function automatic void push_frame(input logic [7:0] h1, input logic [7:0] h0,
                                       input logic [7:0] m1, input logic [7:0] m0,
                                       input logic alarm);
        logic [7:0] txt[$];
        txt = '{h1, h0, 8'h3A, m1, m0};
        if (ICON_EN) begin
            txt.push_back(8'h20);
            txt.push_back(alarm ? 8'h2A : 8'h20);
        end
        exp_q.push_back({1'b0, 8'h80});
        foreach (txt[i]) exp_q.push_back({1'b1, txt[i]});
    endfunction

    function automatic logic [7:0] rand_digit();
        return 8'(8'h30 + $urandom_range(0, 9));
    endfunction

    task automatic set_chars(input logic [7:0] h1, input logic [7:0] h0,
                             input logic [7:0] m1, input logic [7:0] m0);
        display_time_ms_hr  = h1;
        display_time_ls_hr  = h0;
        display_time_ms_min = m1;
        display_time_ls_min = m0;
    endtask

    task automatic check_reset_vals();
        check("rst_ready", ready, 0);
        check("rst_lcd_en", lcd_en, 0);
        check("rst_lcd_rs", lcd_rs, 0);
        check("rst_lcd_rw", lcd_rw, 0);
        check("rst_lcd_data", lcd_data, 0);
    endtask

    // Releases reset and follows init; optionally pulses refresh before IDLE to exercise pending
    task automatic run_init(input bit pend);
        int cyc      = 0;
        int first_en = -1;
        int pcyc     = $urandom_range(2, 90);
        push_init();
        if (pend) push_frame(display_time_ms_hr, display_time_ls_hr,
                             display_time_ms_min, display_time_ls_min, sound_alarm);
        reset_n = 1'b1;
        while (cyc < INIT_LEN + 40) begin
            step();
            cyc++;
            if (pend) refresh = (cyc == pcyc);
            if (first_en < 0 && lcd_en) first_en = cyc;
            if (ready) break;
        end
        refresh = 1'b0;
        check("init_first_en_cycle", first_en, POWER_WAIT + TICK);
        check("init_ready_cycle", cyc, INIT_LEN);
        check("init_bytes_seen", exp_q.size(), pend ? FRAME_BYTES : 0);
        if (pend) begin
            step();
            check("pending_frame_start", ready, 0);
            cyc = 0;
            while (cyc < FRAME_LEN + 20) begin
                step();
                cyc++;
                if (ready) break;
            end
            check("pending_frame_len", cyc, FRAME_LEN);
            check("pending_frame_drained", exp_q.size(), 0);
        end
    endtask

    task automatic run_frame(input logic [7:0] h1, input logic [7:0] h0,
                             input logic [7:0] m1, input logic [7:0] m0,
                             input logic alarm, input logic [7:0] chg, input bit collapse);
        int cyc = 0;
        int p1  = $urandom_range(2, 30);
        int p2  = $urandom_range(31, 60);
        set_chars(h1, h0, m1, m0);
        sound_alarm = alarm;
        push_frame(h1, h0, m1, m0, alarm);
        if (collapse) push_frame(h1, h0, m1, m0, alarm);
        refresh = 1'b1;
        step();
        refresh = 1'b0;
        check("frame_ready_drop", ready, 0);
        while (cyc < FRAME_LEN + 20) begin
            step();
            cyc++;
            if (collapse) begin
                // last pulse lands in the final HOLD cycle
                refresh = (cyc == p1 || cyc == p2 || cyc == FRAME_LEN - 1);
            end else if (cyc == p1) begin
                set_chars(chg, chg, chg, chg);
                sound_alarm = ~alarm;
            end
            if (ready) break;
        end
        refresh = 1'b0;
        check("frame_len", cyc, FRAME_LEN);
        check("frame_bytes_seen", exp_q.size(), collapse ? FRAME_BYTES : 0);
        if (collapse) begin
            step();
            check("collapse_idle_one_cycle", ready, 0);
            cyc = 0;
            while (cyc < FRAME_LEN + 20) begin
                step();
                cyc++;
                if (ready) break;
            end
            check("collapse_frame_len", cyc, FRAME_LEN);
            repeat (2 * 3 * TICK) step();
            check("collapse_single_extra", ready, 1);
            check("collapse_drained", exp_q.size(), 0);
        end
    endtask

    task automatic run_reset_mid_frame();
        int cyc = 0;
        set_chars(rand_digit(), rand_digit(), rand_digit(), rand_digit());
        push_frame(display_time_ms_hr, display_time_ls_hr,
                   display_time_ms_min, display_time_ls_min, sound_alarm);
        refresh = 1'b1;
        step();
        refresh = 1'b0;
        // third data byte (the colon) is in its STROBE phase here
        while (cyc < 9 * TICK + TICK + 1) begin
            step();
            cyc++;
        end
        check("en_high_before_reset", lcd_en, 1);
        reset_n = 1'b0;
        #1;
        check_reset_vals();
        exp_q.delete();
        repeat (3) step();
        run_init(1'b1);
    endtask

    // Monitor: one bus write completes at each EN falling edge
    initial begin
        logic en_prev = 1'b0;
        int   en_len  = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                en_prev = 1'b0;
                en_len  = 0;
            end else begin
                if (lcd_en) en_len++;
                if (en_prev && !lcd_en) begin
                    check("en_pulse_len", en_len, TICK);
                    en_len = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_byte: got rs=%0b data=0x%02h, queue empty", lcd_rs, lcd_data);
                    end else begin
                        check("lcd_byte", {lcd_rs, lcd_data}, exp_q.pop_front());
                    end
                end
                if (ready) check("en_low_in_idle", lcd_en, 0);
                en_prev = lcd_en;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n     = 1'b0;
        refresh     = 1'b0;
        sound_alarm = 1'b0;
        set_chars(8'h20, 8'h20, 8'h20, 8'h20);
        repeat (3) step();
        check_reset_vals();

        run_init(1'b0);

        run_frame(8'h31, 8'h32, 8'h33, 8'h34, 1'b1, 8'h39, 1'b0);
        repeat (2) step();
        run_frame(8'h31, 8'h32, 8'h33, 8'h34, 1'b0, 8'h39, 1'b0);
        step();
        run_frame(rand_digit(), rand_digit(), rand_digit(), rand_digit(), 1'b1, 8'h39, 1'b1);

        for (int n = 0; n < 5; n++) begin
            repeat ($urandom_range(0, 4)) step();
            run_frame(rand_digit(), rand_digit(), rand_digit(), rand_digit(),
                      1'($urandom_range(0, 1)), 8'($urandom_range(65, 90)), 1'b0);
        end

        run_reset_mid_frame();

        repeat (3) step();
        run_frame(rand_digit(), rand_digit(), rand_digit(), rand_digit(),
                  1'($urandom_range(0, 1)), 8'($urandom_range(65, 90)), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aclk_lcd_writer.md
# aclk_lcd_writer

Sequential back end of the alarm-clock display path. Takes the four ASCII characters produced by `aclk_lcd_display` and writes them to an HD44780-compatible character LCD over its 8-bit parallel bus. It runs the power-up init sequence, then on each refresh request snapshots the characters and writes one "HH:MM" frame. It generates all RS/EN strobe timing.

## Interface
Parameters:
- `TICK`, 4: clock cycles per bus phase (setup, EN high, hold); legal range is 1 or more.
- `POWER_WAIT`, 16: idle cycles after reset release before the first command; legal range is 1 or more.
- `CLEAR_WAIT`, 32: extra cycles after the clear command (0x01) completes.

Ports:
- `clk` in 1: single clock for the whole block.
- `reset_n` in 1: reset, asynchronous and active-low.
- `display_time_ms_hr`, `display_time_ls_hr`, `display_time_ms_min`, `display_time_ls_min` in 8 each: ASCII characters to show.
- `sound_alarm` in 1: alarm-active flag, used only with the icon feature.
- `refresh` in 1: single-cycle frame request.
- `ready` out 1: high only in IDLE.
- `lcd_rs` out 1: 0 = command, 1 = data.
- `lcd_rw` out 1: tied to 0 (write-only).
- `lcd_en` out 1: enable strobe.
- `lcd_data` out 8: bus byte.

## Operation
**States.** PWR_WAIT → INIT → IDLE → FRAME → IDLE.

**PWR_WAIT.** Count `POWER_WAIT` cycles, then go to INIT.

**INIT.** Write the commands 0x38, 0x0C, 0x06, 0x01 in that order with `lcd_rs`=0.
- After 0x01, wait `CLEAR_WAIT` cycles.
- Then go to IDLE.
- A `refresh` pulse during PWR_WAIT or INIT sets the pending flag.

**IDLE.** `ready`=1. The block enters FRAME when `refresh`=1 or the pending flag is set.

**FRAME.** On entry, latch all four characters and `sound_alarm` into snapshot registers. Input changes after entry do not affect the frame. Clear the pending flag. Bytes written:
- 0x80 with rs=0 (DDRAM address 0).
- ms_hr, ls_hr, 0x3A (':'), ms_min, ls_min, all with rs=1.
- The optional icon bytes (see Configuration).
- After the last byte, return to IDLE.

**Refresh while busy.** A `refresh` pulse while not in IDLE sets a single sticky pending flag. Multiple pulses collapse into one extra frame.

**Simultaneous events.** If `refresh` arrives in the same cycle as the frame's final hold cycle, it sets pending. The block passes through IDLE for exactly one cycle (`ready`=1), then starts the next frame.

**Byte write, three phases of `TICK` cycles each:**
- SETUP: drive rs/data, en=0.
- STROBE: en=1.
- HOLD: en=0, rs/data held.

`lcd_data` and `lcd_rs` are stable for the entire byte. Between bytes, `lcd_data` keeps its last value.

## Timing
- **Reset values (asynchronous):**
  - `ready`=0, `lcd_en`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_data`=0x00.
  - State PWR_WAIT; counters and pending flag cleared; snapshot registers 0x20.
- **Reset mid-operation:** all outputs drop to the reset values immediately. The full init sequence reruns.
- **Byte cost:** 3·TICK cycles.
- **Init length:** POWER_WAIT + 4·3·TICK + CLEAR_WAIT cycles from `reset_n` release to `ready`=1. With defaults this is 16+48+32 = 96.
- **Frame latency:** `refresh` sampled high at edge N gives `ready`=0 from N+1, and the first SETUP phase starts at N+1.
- **Frame length:** 6·3·TICK cycles, or 8·3·TICK with the icon. With defaults this is 72 (96).
- **EN pulse:** high for exactly TICK consecutive cycles per byte; never high in PWR_WAIT, IDLE, or the clear wait.
- **Counter width:** $clog2 of the largest parameter plus 1; no counter wraps within a phase.

## Configuration
- `ACLK_LCD_ALARM_ICON_EN` defined: each frame appends two data bytes after ls_min.
  - First byte: 0x20.
  - Second byte: 0x2A ('*') if the snapshot of `sound_alarm`=1, else 0x20.
- Macro undefined: frame is 6 bytes and `sound_alarm` is unused.

## Structure
- Package `aclk_lcd_pkg` holds:
  - the state enum;
  - command constants `LCD_FUNC_SET`=0x38, `LCD_DISP_ON`=0x0C, `LCD_ENTRY`=0x06, `LCD_CLEAR`=0x01, `LCD_HOME_ADDR`=0x80;
  - character constants `ASCII_COLON`=0x3A, `ASCII_SPACE`=0x20, `ASCII_STAR`=0x2A.
- One sub-module, `aclk_lcd_byte_writer`:
  - Inputs: `start`, rs, data, `TICK`.
  - Outputs: `lcd_en`/`lcd_rs`/`lcd_data`, plus a single-cycle `done` in the last HOLD cycle.
- The top-level FSM sequences bytes through this sub-module.

## Test plan
1. **Reset values and EN timing:** assert `reset_n`=0 mid-sim → all outputs are at reset values in the same timestep. Release → first `lcd_en` rises at cycle 16+4 and stays high 4 cycles.
2. **Init sequence and ready time:** let init run → bytes captured on the falling edge of EN are 0x38, 0x0C, 0x06, 0x01 with rs=0. `ready` rises 96 cycles after release.
3. **Frame content and snapshot:** characters "1","2","3","4" (0x31, 0x32, 0x33, 0x34), then one `refresh` pulse → 0x80 (rs=0) followed by 0x31, 0x32, 0x3A, 0x33, 0x34 (rs=1). Changing the inputs to "9" mid-frame does not alter the frame. `ready` returns after 72 cycles.
4. **Collapsed refresh requests:** three `refresh` pulses during a frame → exactly one additional frame, preceded by one IDLE cycle.
5. **Reset mid-frame:** assert `reset_n`=0 during the third data byte → EN drops immediately. After release, the full init sequence repeats before any data byte.
6. **Alarm icon:** with `ACLK_LCD_ALARM_ICON_EN` defined and `sound_alarm`=1 → frame ends 0x20, 0x2A. With `sound_alarm`=0 → frame ends 0x20, 0x20. Macro undefined → 6-byte frame.
